// File: rtl/player_state_ctrl_pkg.sv
// rtl/player_state_ctrl_pkg.sv - shared FSM encoding, register map and CTRL bits
package player_state_ctrl_pkg;

  typedef enum logic [1:0] {
    PSC_IDLE   = 2'd0,
    PSC_ARMED  = 2'd1,
    PSC_COMMIT = 2'd2
  } psc_state_e;

  localparam logic [2:0] ADDR_SHADOW_X   = 3'd0;
  localparam logic [2:0] ADDR_SHADOW_Y   = 3'd1;
  localparam logic [2:0] ADDR_SHADOW_DIR = 3'd2;
  localparam logic [2:0] ADDR_CTRL       = 3'd3;
  localparam logic [2:0] ADDR_STATUS     = 3'd3;
  localparam logic [2:0] ADDR_FRAME_CNT  = 3'd4;
  localparam logic [2:0] ADDR_COMMIT_CNT = 3'd5;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;

endpackage

// File: rtl/player_state_ctrl_if.sv
// rtl/player_state_ctrl_if.sv - Avalon-MM register bus for the player state block
interface player_state_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/psc_regfile.sv
// rtl/psc_regfile.sv - shadow player registers and zero-latency read mux
module psc_regfile
  import player_state_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [2:0]        address,
  input  logic [DATA_W-1:0] writedata,
  input  logic [1:0]        status,
  input  logic [FCNT_W-1:0] frame_cnt,
  input  logic [FCNT_W-1:0] commit_cnt,
  output logic [DATA_W-1:0] shadow_x,
  output logic [DATA_W-1:0] shadow_y,
  output logic [DATA_W-1:0] shadow_dir,
  output logic [DATA_W-1:0] readdata
);

  // Shadow registers take bus writes in every FSM state; other addresses are ignored here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x   <= '0;
      shadow_y   <= '0;
      shadow_dir <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_SHADOW_X:   shadow_x   <= writedata;
        ADDR_SHADOW_Y:   shadow_y   <= writedata;
        ADDR_SHADOW_DIR: shadow_dir <= writedata;
        default: ;
      endcase
    end
  end

  // Read mux sees register values from before the edge, so read-during-write returns old data
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_SHADOW_X:   readdata = shadow_x;
      ADDR_SHADOW_Y:   readdata = shadow_y;
      ADDR_SHADOW_DIR: readdata = shadow_dir;
      ADDR_STATUS:     readdata = DATA_W'(status);
      ADDR_FRAME_CNT:  readdata = DATA_W'(frame_cnt);
      ADDR_COMMIT_CNT: readdata = DATA_W'(commit_cnt);
      default:         readdata = '0;
    endcase
  end

endmodule

// File: rtl/player_state_ctrl.sv
// rtl/player_state_ctrl.sv - double-buffered player state committed at vertical blanking
module player_state_ctrl
  import player_state_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FCNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  player_state_ctrl_if.slave   bus,
  input  logic                 frame_start,
  output logic [DATA_W-1:0]    player_x,
  output logic [DATA_W-1:0]    player_y,
  output logic [DATA_W-1:0]    player_dir,
  output logic                 update_pulse
);

  localparam logic [1:0] IDLE   = PSC_IDLE;
  localparam logic [1:0] ARMED  = PSC_ARMED;
  localparam logic [1:0] COMMIT = PSC_COMMIT;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [FCNT_W-1:0] frame_cnt;
  logic [FCNT_W-1:0] commit_cnt;
  logic [DATA_W-1:0] shadow_x;
  logic [DATA_W-1:0] shadow_y;
  logic [DATA_W-1:0] shadow_dir;
  logic              wr_en;
  logic              ctrl_wr;
  logic              arm_req;
  logic              abort_req;
  logic [1:0]        status;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign ctrl_wr   = wr_en && (bus.address == ADDR_CTRL);
  assign arm_req   = ctrl_wr && bus.writedata[CTRL_ARM];
  assign abort_req = ctrl_wr && bus.writedata[CTRL_ABORT];
  assign status    = {state == COMMIT, state == ARMED};

  psc_regfile #(
    .DATA_W (DATA_W),
    .FCNT_W (FCNT_W)
  ) u_regfile (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .address    (bus.address),
    .writedata  (bus.writedata),
    .status     (status),
    .frame_cnt  (frame_cnt),
    .commit_cnt (commit_cnt),
    .shadow_x   (shadow_x),
    .shadow_y   (shadow_y),
    .shadow_dir (shadow_dir),
    .readdata   (bus.readdata)
  );

  // Next-state: abort beats frame_start while armed; arm in IDLE ignores a coincident frame_start
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arm_req) next_state = ARMED;
      ARMED: begin
        if (abort_req)        next_state = IDLE;
        else if (frame_start) next_state = COMMIT;
      end
      COMMIT:  next_state = arm_req ? ARMED : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; an asynchronous reset abandons any pending commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Commit copies the shadows as they stand during COMMIT and flags the change for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      player_x     <= '0;
      player_y     <= '0;
      player_dir   <= '0;
      commit_cnt   <= '0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= (state == COMMIT);
      if (state == COMMIT) begin
        player_x   <= shadow_x;
        player_y   <= shadow_y;
        player_dir <= shadow_dir;
        commit_cnt <= commit_cnt + FCNT_W'(1);
      end
    end
  end

  // Frame counter advances on every frame_start regardless of FSM state, wrapping naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + FCNT_W'(1);
  end

endmodule
